// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-side bus bundle: PC handshake, instruction memory req/ack, decode queue head.
// With IFETCH_ALIGN_CHK_EN defined, the bundle also carries if_misalign.
interface inst_fetch_ctrl_if #(
  parameter int WORD_WIDTH = 32
);
  logic [WORD_WIDTH-1:0] pc_addr;
  logic                  flush;
  logic                  pc_stall;
  logic                  im_req;
  logic [WORD_WIDTH-1:0] im_addr;
  logic                  im_ack;
  logic [WORD_WIDTH-1:0] im_rdata;
  logic                  id_stall;
  logic                  if_valid;
  logic [WORD_WIDTH-1:0] if_inst;
  logic [WORD_WIDTH-1:0] if_pc;
`ifdef IFETCH_ALIGN_CHK_EN
  logic                  if_misalign;
`endif

  modport slave (
    input  pc_addr, flush, im_ack, im_rdata, id_stall,
    output pc_stall, im_req, im_addr, if_valid, if_inst, if_pc
`ifdef IFETCH_ALIGN_CHK_EN
    , output if_misalign
`endif
  );

  modport master (
    output pc_addr, flush, im_ack, im_rdata, id_stall,
    input  pc_stall, im_req, im_addr, if_valid, if_inst, if_pc
`ifdef IFETCH_ALIGN_CHK_EN
    , input if_misalign
`endif
  );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch responder: issues req/ack memory reads and queues {pc, inst} for decode.
// Optional IFETCH_ALIGN_CHK_EN turns misaligned PCs into NOP entries tagged if_misalign.
module inst_fetch_ctrl #(
  parameter int                    WORD_WIDTH = 32,
  parameter int                    DEPTH      = 2,
  parameter logic [WORD_WIDTH-1:0] NOP_INST   = '0
) (
  input logic               clk,
  input logic               rst,
  inst_fetch_ctrl_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d, count_after;
  logic [WORD_WIDTH-1:0] addr_mem [DEPTH];
  logic [WORD_WIDTH-1:0] inst_mem [DEPTH];
  logic                  push, pop, push_mis, full, empty;
  logic [WORD_WIDTH-1:0] push_addr, push_inst;
`ifdef IFETCH_ALIGN_CHK_EN
  logic [DEPTH-1:0]      mis_mem;
`endif

  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH_C);
  assign pop         = !empty && !bus.id_stall;
  assign count_after = count_q + CW'(1) - CW'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Payload storage needs no reset: reads are masked by the empty check.
  always_ff @(posedge clk) begin
    if (push && !bus.flush) begin
      addr_mem[wr_ptr_q] <= push_addr;
      inst_mem[wr_ptr_q] <= push_inst;
`ifdef IFETCH_ALIGN_CHK_EN
      mis_mem[wr_ptr_q]  <= push_mis;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    push       = 1'b0;
    push_addr  = req_addr_q;
    push_inst  = bus.im_rdata;
    push_mis   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.flush && !full) begin
`ifdef IFETCH_ALIGN_CHK_EN
          if (bus.pc_addr[1:0] != 2'b00) begin
            push      = 1'b1;
            push_addr = bus.pc_addr;
            push_inst = NOP_INST;
            push_mis  = 1'b1;
          end else begin
            req_addr_d = bus.pc_addr;
            state_d    = WAIT;
          end
`else
          req_addr_d = bus.pc_addr;
          state_d    = WAIT;
`endif
        end
      end
      WAIT: begin
        // The read still completes on a flush without ack, so DRAIN swallows it.
        if (bus.im_ack) begin
          if (bus.flush) begin
            state_d = IDLE;
          end else begin
            push = 1'b1;
            if (count_after < DEPTH_C) req_addr_d = req_addr_q + WORD_WIDTH'(4);
            else                       state_d    = IDLE;
          end
        end else if (bus.flush) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.im_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  assign bus.im_req   = (state_q != IDLE);
  assign bus.im_addr  = req_addr_q;
  assign bus.pc_stall = !(bus.flush || ((state_q == WAIT) && bus.im_ack));
  assign bus.if_valid = !empty;
  assign bus.if_inst  = empty ? NOP_INST : inst_mem[rd_ptr_q];
  assign bus.if_pc    = empty ? '0 : addr_mem[rd_ptr_q];
`ifdef IFETCH_ALIGN_CHK_EN
  assign bus.if_misalign = !empty && mis_mem[rd_ptr_q];
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: directed scenarios then random traffic vs a queue model.
// Also exercises the IFETCH_ALIGN_CHK_EN build when that macro is defined.
module tb_inst_fetch_ctrl;
  localparam int          W     = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        mis;
  } entry_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_fetch_ctrl_if #(.WORD_WIDTH(W)) bus ();

  inst_fetch_ctrl #(.WORD_WIDTH(W), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  entry_t      m_q[$];
  bit          m_busy, m_discard;
  logic [31:0] m_addr, pc_model;
  int          cmp_cnt = 0;
  int          fail_cnt = 0;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp)
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void modelReset();
    m_q.delete();
    m_busy    = 1'b0;
    m_discard = 1'b0;
    m_addr    = '0;
  endfunction

  // One clock of the fetch rules, applied to the abstract queue/outstanding-read view.
  function automatic void modelStep(bit f, bit st, bit ak, logic [31:0] rd, logic [31:0] pc);
    bit     pop     = (m_q.size() > 0) && !st;
    bit     do_push = 1'b0;
    entry_t e;
    e.pc = '0; e.inst = '0; e.mis = 1'b0;
    if (m_busy && !m_discard) begin
      if (ak && !f) begin
        do_push = 1'b1;
        e.pc = m_addr; e.inst = rd; e.mis = 1'b0;
        if (m_q.size() + 1 - int'(pop) < DEPTH) m_addr = m_addr + 32'd4;
        else m_busy = 1'b0;
      end else if (ak) begin
        m_busy = 1'b0;
      end else if (f) begin
        m_discard = 1'b1;
      end
    end else if (m_busy) begin
      if (ak) begin
        m_busy    = 1'b0;
        m_discard = 1'b0;
      end
    end else if (!f && m_q.size() < DEPTH) begin
`ifdef IFETCH_ALIGN_CHK_EN
      if (pc[1:0] != 2'b00) begin
        do_push = 1'b1;
        e.pc = pc; e.inst = NOP; e.mis = 1'b1;
      end else begin
        m_busy = 1'b1;
        m_addr = pc;
      end
`else
      m_busy = 1'b1;
      m_addr = pc;
`endif
    end
    if (f) m_q.delete();
    else begin
      if (pop) void'(m_q.pop_front());
      if (do_push) m_q.push_back(e);
    end
  endfunction

  task automatic checkOutput();
    cmp("im_req", {31'd0, bus.im_req}, {31'd0, m_busy});
    if (m_busy) cmp("im_addr", bus.im_addr, m_addr);
    cmp("pc_stall", {31'd0, bus.pc_stall},
        {31'd0, !(bus.flush || (m_busy && !m_discard && bus.im_ack))});
    cmp("if_valid", {31'd0, bus.if_valid}, {31'd0, m_q.size() > 0});
    if (m_q.size() > 0) begin
      cmp("if_pc", bus.if_pc, m_q[0].pc);
      cmp("if_inst", bus.if_inst, m_q[0].inst);
    end else begin
      cmp("if_inst_empty", bus.if_inst, NOP);
    end
`ifdef IFETCH_ALIGN_CHK_EN
    cmp("if_misalign", {31'd0, bus.if_misalign},
        {31'd0, (m_q.size() > 0) ? m_q[0].mis : 1'b0});
`endif
  endtask

  task automatic applyStimulus(input bit f, input bit st, input bit ak, input logic [31:0] tgt);
    logic [31:0] rd_l, pc_l;
    bit          ack_l, stall_l;
    @(negedge clk);
    ack_l        = ak && m_busy;
    rd_l         = m_addr ^ 32'hA5A5_A5A5;
    pc_l         = pc_model;
    bus.flush    = f;
    bus.id_stall = st;
    bus.im_ack   = ack_l;
    bus.im_rdata = rd_l;
    bus.pc_addr  = pc_l;
    #1;
    checkOutput();
    stall_l = !(f || (m_busy && !m_discard && ack_l));
    @(posedge clk);
    modelStep(f, st, ack_l, rd_l, pc_l);
    if (f) pc_model = tgt;
    else if (!stall_l) pc_model = pc_model + 32'd4;
  endtask

  task automatic checkReset(input string tag);
    cmp({tag, "_im_req"},   {31'd0, bus.im_req},   32'd0);
    cmp({tag, "_if_valid"}, {31'd0, bus.if_valid}, 32'd0);
    cmp({tag, "_if_inst"},  bus.if_inst,           NOP);
    cmp({tag, "_if_pc"},    bus.if_pc,             32'd0);
    cmp({tag, "_pc_stall"}, {31'd0, bus.pc_stall}, 32'd1);
  endtask

  initial begin
    rst          = 1'b1;
    bus.flush    = 1'b0;
    bus.id_stall = 1'b0;
    bus.im_ack   = 1'b0;
    bus.im_rdata = '0;
    bus.pc_addr  = '0;
    pc_model     = '0;
    modelReset();
    repeat (2) @(negedge clk);
    #1;
    checkReset("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] zero-wait streaming from 0x0");
    repeat (8) applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);

    $display("[TB] decode stall fills the queue");
    repeat (6) applyStimulus(1'b0, 1'b1, 1'b1, 32'h0);
    #1;
    cmp("full_im_req", {31'd0, bus.im_req}, 32'd0);
    cmp("full_pc_stall", {31'd0, bus.pc_stall}, 32'd1);
    cmp("full_if_valid", {31'd0, bus.if_valid}, 32'd1);
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);

    $display("[TB] three-cycle memory latency");
    repeat (3) begin
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
    end

    $display("[TB] flush with an outstanding read");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h10);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h40);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);

    $display("[TB] flush coinciding with ack");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h80);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);

    $display("[TB] address wrap");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
    repeat (7) applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);

    $display("[TB] reset mid-transaction");
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    bus.flush  = 1'b0;
    bus.im_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkReset("midrst");
    modelReset();
`ifdef IFETCH_ALIGN_CHK_EN
    pc_model = 32'h6;
`else
    pc_model = 32'h0;
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h20);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);

    $display("[TB] random traffic");
    repeat (2000) begin
      bit          f, st, ak;
      logic [31:0] tgt;
      f   = ($urandom_range(0, 9) == 0);
      st  = ($urandom_range(0, 3) == 0);
      ak  = ($urandom_range(0, 2) != 0);
      tgt = $urandom & 32'hFFFF_FFFC;
`ifdef IFETCH_ALIGN_CHK_EN
      if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
`endif
      applyStimulus(f, st, ak, tgt);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end
endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
Instruction-fetch responder that sits between the program counter and instruction memory. It accepts the PC's current fetch address and issues req/ack reads to instruction memory. Returned words are buffered in a small queue that feeds decode as {pc, instruction} pairs. It drives the PC stall and absorbs jump flushes, including discarding a read that is already in flight.

Parameters:
WORD_WIDTH, 32, width of address, instruction and data words.
DEPTH, 2, instruction queue entries; power of two, >= 2.
NOP_INST, 32'h0000_0000, value driven on if_inst when the queue is empty or in reset.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  asynchronous, active-high reset.
pc_addr  in  WORD_WIDTH  current fetch address from the program counter.
flush  in  1  jump taken this cycle; the PC loads the target on this edge.
pc_stall  out  1  hold the PC; 0 lets the PC advance or jump.
im_req  out  1  instruction memory read request.
im_addr  out  WORD_WIDTH  read address; stable while im_req is high.
im_ack  in  1  memory returns im_rdata this cycle.
im_rdata  in  WORD_WIDTH  read data, valid with im_ack.
id_stall  in  1  decode cannot accept the head entry.
if_valid  out  1  queue head is valid.
if_inst  out  WORD_WIDTH  head instruction, or NOP_INST when empty.
if_pc  out  WORD_WIDTH  head address.

Behaviour:
- Reset (asynchronous):
  - state=IDLE, queue empty, req_addr=0.
  - Outputs: im_req=0, if_valid=0, if_inst=NOP_INST, if_pc=0, pc_stall=1.
- FSM states: IDLE, WAIT, DRAIN.
- IDLE:
  - im_req=0.
  - If ~flush and the queue is not full: req_addr<=pc_addr, go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - im_req=1, im_addr=req_addr.
  - im_req stays high until im_ack; it never drops mid-transaction.
  - A request is only issued while the queue has space, and entries only leave the queue, so space is guaranteed when im_ack arrives.
- WAIT & im_ack & ~flush:
  - Push {req_addr, im_rdata}.
  - If the queue count after push < DEPTH: req_addr<=req_addr+4 (mod 2^WORD_WIDTH, wrap allowed), stay in WAIT. This gives one instruction per cycle on a zero-wait memory.
  - Else go to IDLE.
- WAIT & im_ack & flush: discard the data, go to IDLE.
- WAIT & ~im_ack & flush: go to DRAIN; keep im_req and im_addr unchanged.
- DRAIN:
  - im_req=1 with the old req_addr.
  - On im_ack, discard the data and go to IDLE.
  - A flush arriving while in DRAIN keeps the state in DRAIN.
- pc_stall (combinational):
  - 0 when flush=1.
  - 0 when state==WAIT & im_ack & ~flush.
  - 1 otherwise.
  - This keeps pc_addr equal to req_addr+4 after every accepted word.
- Queue:
  - Pop when if_valid & ~id_stall.
  - flush clears all entries on the same edge; if_valid=0 the next cycle.
  - Push and pop in the same cycle are legal; the count is unchanged.
  - flush overrides any push or pop in that cycle.
- Latency: im_req rises 1 cycle after leaving IDLE. A pushed entry is visible on if_* the cycle after im_ack.

Optional Feature:
Macro: IFETCH_ALIGN_CHK_EN.
- Defined:
  - Extra output port if_misalign (1 bit); each entry carries a misalign bit.
  - In IDLE, if pc_addr[1:0]!=0 and the queue has space: no memory request. Push {pc_addr, NOP_INST, misalign=1} directly and stay in IDLE.
  - if_misalign=1 with the head entry; it is 0 in reset and when the queue is empty.
  - A WAIT-state sequential increment never misaligns, so it needs no check.
- Undefined: no port and no check; address bits [1:0] pass to im_addr unchanged.

Test Plan:
1. Reset release, pc_addr=0x0, memory acks every cycle with rdata=addr^0xA5A5A5A5 -> im_addr 0x0, 0x4, 0x8, ... on consecutive cycles; if_pc/if_inst match in order from cycle 3; pc_stall low on each ack cycle.
2. id_stall=1 held with DEPTH=2 -> exactly 2 entries queued (0x0, 0x4); FSM in IDLE, im_req=0, pc_stall=1. Release id_stall -> entries pop in order, then fetch resumes at 0x8.
3. Memory with 3-cycle ack latency -> im_req and im_addr stable for 3 cycles; pc_stall=1 except the ack cycle; one entry per 4 cycles.
4. flush while WAIT at 0x10 with ack delayed 2 cycles, pc_addr->0x40 -> queue empties next cycle; DRAIN holds im_addr=0x10 until ack; data discarded; next request is 0x40, with if_pc=0x40 as the first valid entry.
5. flush in the same cycle as im_ack at 0x8 -> word 0x8 never appears on if_*; next fetch is at the jump target.
6. Assert rst mid-WAIT -> im_req=0, if_valid=0, if_inst=NOP_INST, if_pc=0, pc_stall=1 immediately. With IFETCH_ALIGN_CHK_EN, pc_addr=0x6 after reset -> no im_req; if_valid=1, if_misalign=1, if_pc=0x6, if_inst=NOP_INST.
